// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the decode-stage hazard scoreboard: shadow slot
// layout and the EXE forward-select encoding.
package hazard_scoreboard_pkg;

    localparam int SLOT_REG_W = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_REG_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_r;
        logic [SLOT_REG_W-1:0] src1;
        logic [SLOT_REG_W-1:0] src2;
        logic                  use1;
        logic                  use2;
    } slot_t;

    // The nearer producer (current EXE, which becomes MEM) wins a double match.
    function automatic logic [1:0] fwd_pick(input logic hit_exe, input logic hit_mem);
        if (hit_exe)
            return FWD_MEM;
        else if (hit_mem)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_hz_slot_match.sv
// Compares one decode-stage source register against one shadow slot.
module hz_slot_match #(
    parameter int REG_W = 4
) (
    input  logic             slot_valid,
    input  logic             slot_wb_en,
    input  logic [REG_W-1:0] slot_dest,
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    output logic             hit
);

    assign hit = use_src & slot_valid & slot_wb_en & (slot_dest == src);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard responder: shadow EXE/MEM/WB destination pipeline,
// same-cycle stall request, registered EXE forward selects and stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] src1_HZRD,
    input  logic [REG_W-1:0] src2_HZRD,
    input  logic             two_src_HZRD,
    input  logic             move_HZRD,
    input  logic [REG_W-1:0] dest_ID,
    input  logic             WB_EN_ID,
    input  logic             MEM_R_EN_ID,
    input  logic             flush,
    output logic             hazard,
    output logic [1:0]       fwd_sel1_EXE,
    output logic [1:0]       fwd_sel2_EXE,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t      slot_exe_p0;
    slot_t      slot_mem_p1;
    slot_t      slot_wb_p2;
    slot_t      slot_new;

    logic       use1;
    logic       use2;
    logic       h1_exe;
    logic       h2_exe;
    logic       h1_mem;
    logic       h2_mem;
    logic       hit_exe;
    logic       hit_mem;
    logic       issue;
    logic [1:0] sel1_nxt;
    logic [1:0] sel2_nxt;

    // WB slot is kept for visibility only; the register file is write-before-read.
    logic       shadow_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign use1 = ~move_HZRD;
    assign use2 = two_src_HZRD;

    hz_slot_match #(.REG_W(REG_W)) u_m1_exe (
        .slot_valid (slot_exe_p0.valid),
        .slot_wb_en (slot_exe_p0.wb_en),
        .slot_dest  (slot_exe_p0.dest),
        .src        (src1_HZRD),
        .use_src    (use1),
        .hit        (h1_exe)
    );

    hz_slot_match #(.REG_W(REG_W)) u_m2_exe (
        .slot_valid (slot_exe_p0.valid),
        .slot_wb_en (slot_exe_p0.wb_en),
        .slot_dest  (slot_exe_p0.dest),
        .src        (src2_HZRD),
        .use_src    (use2),
        .hit        (h2_exe)
    );

    hz_slot_match #(.REG_W(REG_W)) u_m1_mem (
        .slot_valid (slot_mem_p1.valid),
        .slot_wb_en (slot_mem_p1.wb_en),
        .slot_dest  (slot_mem_p1.dest),
        .src        (src1_HZRD),
        .use_src    (use1),
        .hit        (h1_mem)
    );

    hz_slot_match #(.REG_W(REG_W)) u_m2_mem (
        .slot_valid (slot_mem_p1.valid),
        .slot_wb_en (slot_mem_p1.wb_en),
        .slot_dest  (slot_mem_p1.dest),
        .src        (src2_HZRD),
        .use_src    (use2),
        .hit        (h2_mem)
    );

    assign hit_exe = h1_exe | h2_exe;
    assign hit_mem = h1_mem | h2_mem;

    // With forwarding only a load still in EXE cannot supply its result in time.
    assign hazard = fwd_en ? (hit_exe & slot_exe_p0.mem_r) : (hit_exe | hit_mem);
    assign issue  = ~hazard & ~flush;

    assign sel1_nxt = (fwd_en & issue) ? fwd_pick(h1_exe, h1_mem) : FWD_RF;
    assign sel2_nxt = (fwd_en & issue) ? fwd_pick(h2_exe, h2_mem) : FWD_RF;

    always_comb begin
        slot_new       = '0;
        slot_new.valid = issue;
        slot_new.dest  = dest_ID;
        slot_new.wb_en = WB_EN_ID;
        slot_new.mem_r = MEM_R_EN_ID;
        slot_new.src1  = src1_HZRD;
        slot_new.src2  = src2_HZRD;
        slot_new.use1  = use1;
        slot_new.use2  = use2;
    end

    assign shadow_unused = ^{slot_wb_p2, slot_exe_p0.src1, slot_exe_p0.src2,
                             slot_exe_p0.use1, slot_exe_p0.use2, slot_mem_p1.mem_r,
                             slot_mem_p1.src1, slot_mem_p1.src2, slot_mem_p1.use1,
                             slot_mem_p1.use2};

    // ID -> EXE (p0) -> MEM (p1) -> WB (p2)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_exe_p0.valid <= 1'b0;
            slot_mem_p1.valid <= 1'b0;
            slot_wb_p2.valid  <= 1'b0;
            fwd_sel1_EXE      <= FWD_RF;
            fwd_sel2_EXE      <= FWD_RF;
            stall_cnt         <= '0;
        end else begin
            slot_wb_p2   <= slot_mem_p1;
            slot_mem_p1  <= slot_exe_p0;
            slot_exe_p0  <= slot_new;
            fwd_sel1_EXE <= sel1_nxt;
            fwd_sel2_EXE <= sel2_nxt;
            if (hazard && !flush)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (CNT_W=4 so counter saturation is reachable).
module tb_hazard_scoreboard;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fwd_en = 1'b0;
    logic [3:0]       src1_HZRD = '0;
    logic [3:0]       src2_HZRD = '0;
    logic             two_src_HZRD = 1'b0;
    logic             move_HZRD = 1'b1;
    logic [3:0]       dest_ID = '0;
    logic             WB_EN_ID = 1'b0;
    logic             MEM_R_EN_ID = 1'b0;
    logic             flush = 1'b0;
    logic             hazard;
    logic [1:0]       fwd_sel1_EXE;
    logic [1:0]       fwd_sel2_EXE;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.CNT_W(CNT_W), .REG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .src1_HZRD    (src1_HZRD),
        .src2_HZRD    (src2_HZRD),
        .two_src_HZRD (two_src_HZRD),
        .move_HZRD    (move_HZRD),
        .dest_ID      (dest_ID),
        .WB_EN_ID     (WB_EN_ID),
        .MEM_R_EN_ID  (MEM_R_EN_ID),
        .flush        (flush),
        .hazard       (hazard),
        .fwd_sel1_EXE (fwd_sel1_EXE),
        .fwd_sel2_EXE (fwd_sel2_EXE),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic mov, input logic [3:0] dst, input logic wb,
                         input logic memr);
        src1_HZRD    = s1;
        src2_HZRD    = s2;
        two_src_HZRD = two;
        move_HZRD    = mov;
        dest_ID      = dst;
        WB_EN_ID     = wb;
        MEM_R_EN_ID  = memr;
        #1;
    endtask

    task automatic nop();
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        nop();
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        nop();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0 || fwd_sel1_EXE !== 2'b00 || fwd_sel2_EXE !== 2'b00 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: hazard=%b sel1=%b sel2=%b cnt=%0d, want 0/00/00/0",
                     hazard, fwd_sel1_EXE, fwd_sel2_EXE, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_stall_no_fwd();
        apply_reset();
        fwd_en = 1'b0;
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);   // ADD r1
        tick();
        drive(4'd1, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);   // SUB r4, r1
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_stall_c1: hazard=%b want 1", hazard);
        end
        tick();
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_stall_c2: hazard=%b want 1", hazard);
        end
        tick();
        checks++;
        if (hazard !== 1'b0 || stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL nofwd_release: hazard=%b cnt=%0d want 0/2", hazard, stall_cnt);
        end
        tick();
        checks++;
        if (fwd_sel1_EXE !== 2'b00) begin
            errors++;
            $display("FAIL nofwd_sel: sel1=%b want 00", fwd_sel1_EXE);
        end
        nop();
    endtask

    task automatic test_load_use();
        apply_reset();
        fwd_en = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1);   // LDR r3
        tick();
        drive(4'd0, 4'd3, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);   // ADD r5, r0, r3
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_stall: hazard=%b want 1", hazard);
        end
        tick();
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_release: hazard=%b want 0", hazard);
        end
        tick();
        checks++;
        if (fwd_sel2_EXE !== 2'b10 || fwd_sel1_EXE !== 2'b00 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL loaduse_fwd: sel1=%b sel2=%b cnt=%0d want 00/10/1",
                     fwd_sel1_EXE, fwd_sel2_EXE, stall_cnt);
        end
        nop();
    endtask

    task automatic test_alu_fwd();
        apply_reset();
        fwd_en = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);   // ADD r2
        tick();
        drive(4'd2, 4'd2, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);   // ORR r6, r2, r2
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL alufwd_nohaz: hazard=%b want 0", hazard);
        end
        tick();
        checks++;
        if (fwd_sel1_EXE !== 2'b01 || fwd_sel2_EXE !== 2'b01) begin
            errors++;
            $display("FAIL alufwd_sel: sel1=%b sel2=%b want 01/01", fwd_sel1_EXE, fwd_sel2_EXE);
        end
        // r2 again in EXE and the ORR's r6 two back: nearer producer wins, far one gives WB
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);   // MOV r2
        tick();
        drive(4'd2, 4'd6, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);   // r2 (EXE and WB) and r6 (MEM)
        tick();
        checks++;
        if (fwd_sel1_EXE !== 2'b01 || fwd_sel2_EXE !== 2'b10 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL fwd_priority: sel1=%b sel2=%b cnt=%0d want 01/10/0",
                     fwd_sel1_EXE, fwd_sel2_EXE, stall_cnt);
        end
        nop();
        tick();
        checks++;
        if (fwd_sel1_EXE !== 2'b00 || fwd_sel2_EXE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_bubble: sel1=%b sel2=%b want 00/00", fwd_sel1_EXE, fwd_sel2_EXE);
        end
    endtask

    task automatic test_masked_sources();
        apply_reset();
        fwd_en = 1'b0;
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);   // ADD r7
        tick();
        drive(4'd7, 4'd0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);   // MOV with src1=r7
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL masked_mov: hazard=%b want 0", hazard);
        end
        drive(4'd0, 4'd7, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0);   // immediate op, src2=r7 unused
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL masked_imm: hazard=%b want 0", hazard);
        end
        drive(4'd0, 4'd7, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0);   // same op, src2 really read
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL used_src2: hazard=%b want 1", hazard);
        end
        nop();
    endtask

    task automatic test_flush_overlap();
        apply_reset();
        fwd_en = 1'b0;
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);   // ADD r1
        tick();
        flush = 1'b1;
        drive(4'd1, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0);   // SUB r8, r1 while flushed
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL flush_haz: hazard=%b want 1", hazard);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL flush_cnt: cnt=%0d want 0", stall_cnt);
        end
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);   // MOV r9, no hazard, still flushed
        tick();
        flush = 1'b0;
        drive(4'd9, 4'd8, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0);  // reads both flushed dests
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale: hazard=%b want 0", hazard);
        end
        nop();
    endtask

    task automatic test_saturation_reset();
        apply_reset();
        fwd_en = 1'b0;
        for (int r = 0; r < 10; r++) begin
            drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
            tick();
            drive(4'd1, 4'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
            tick();
            tick();
            tick();
            if (r == 6) begin
                checks++;
                if (stall_cnt !== 4'd14) begin
                    errors++;
                    $display("FAIL cnt_14: cnt=%0d want 14", stall_cnt);
                end
            end
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL cnt_sat: cnt=%0d want 15", stall_cnt);
        end
        fwd_en = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD r4
        tick();
        drive(4'd4, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);   // ORR r5, r4
        tick();
        fwd_en = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b1 || fwd_sel1_EXE !== 2'b01) begin
            errors++;
            $display("FAIL prereset: hazard=%b sel1=%b want 1/01", hazard, fwd_sel1_EXE);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0 || fwd_sel1_EXE !== 2'b00 || fwd_sel2_EXE !== 2'b00 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: hazard=%b sel1=%b sel2=%b cnt=%0d want 0/00/00/0",
                     hazard, fwd_sel1_EXE, fwd_sel2_EXE, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: hazard=%b want 0", hazard);
        end
        nop();
    endtask

    initial begin
        test_reset();
        test_stall_no_fwd();
        test_load_use();
        test_alu_fwd();
        test_masked_sources();
        test_flush_overlap();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
